// File: rtl/y86_pkg.sv
// y86_pkg: shared Y86-64 status codes, icodes and pipeline register types.
// Provides BUB..INS status codes, HALT..POPQ icodes, RNONE, M/W register
// structs with their bubble values, and icode read/write classifiers.
package y86_pkg;
  localparam logic [2:0] BUB = 3'd0, AOK = 3'd1, HLT = 3'd2, ADR = 3'd3, INS = 3'd4;
  localparam logic [3:0] HALT = 4'h0, NOP = 4'h1, RRMOVQ = 4'h2, IRMOVQ = 4'h3,
                         RMMOVQ = 4'h4, MRMOVQ = 4'h5, OPQ = 4'h6, JXX = 4'h7,
                         CALL = 4'h8, RET = 4'h9, PUSHQ = 4'hA, POPQ = 4'hB;
  localparam logic [3:0] RNONE = 4'hF;
  typedef struct packed {
    logic [2:0]  stat;
    logic [3:0]  icode;
    logic        cnd;
    logic [63:0] val_e;
    logic [63:0] val_a;
    logic [3:0]  dst_e;
    logic [3:0]  dst_m;
  } m_reg_t;
  typedef struct packed {
    logic [2:0]  stat;
    logic [3:0]  icode;
    logic [63:0] val_e;
    logic [63:0] val_m;
    logic [3:0]  dst_e;
    logic [3:0]  dst_m;
  } w_reg_t;
  localparam m_reg_t M_BUBBLE = {BUB, NOP, 1'b0, 64'd0, 64'd0, RNONE, RNONE};
  localparam w_reg_t W_BUBBLE = {BUB, NOP, 64'd0, 64'd0, RNONE, RNONE};
  function automatic logic is_read(input logic [3:0] icode);
    return icode == MRMOVQ || icode == POPQ || icode == RET;
  endfunction
  function automatic logic is_write(input logic [3:0] icode);
    return icode == RMMOVQ || icode == PUSHQ || icode == CALL;
  endfunction
endpackage

// File: rtl/memory_stage_if.sv
// memory_stage_if: bundle of execute-side inputs, M/W register outputs and m_* results.
// master: upstream/bench drives e_*, M_bubble, W_stall. slave: the memory stage.
interface memory_stage_if;
  logic [2:0]  e_stat;
  logic [3:0]  e_icode;
  logic        e_Cnd;
  logic [63:0] e_valE;
  logic [63:0] e_valA;
  logic [3:0]  e_dstE;
  logic [3:0]  e_dstM;
  logic        M_bubble;
  logic        W_stall;
  logic [2:0]  M_stat;
  logic [3:0]  M_icode;
  logic        M_Cnd;
  logic [63:0] M_valE;
  logic [63:0] M_valA;
  logic [3:0]  M_dstE;
  logic [3:0]  M_dstM;
  logic [2:0]  m_stat;
  logic [63:0] m_valM;
  logic [2:0]  W_stat;
  logic [3:0]  W_icode;
  logic [63:0] W_valE;
  logic [63:0] W_valM;
  logic [3:0]  W_dstE;
  logic [3:0]  W_dstM;
  modport master (
    output e_stat, e_icode, e_Cnd, e_valE, e_valA, e_dstE, e_dstM, M_bubble, W_stall,
    input  M_stat, M_icode, M_Cnd, M_valE, M_valA, M_dstE, M_dstM, m_stat, m_valM,
    input  W_stat, W_icode, W_valE, W_valM, W_dstE, W_dstM
  );
  modport slave (
    input  e_stat, e_icode, e_Cnd, e_valE, e_valA, e_dstE, e_dstM, M_bubble, W_stall,
    output M_stat, M_icode, M_Cnd, M_valE, M_valA, M_dstE, M_dstM, m_stat, m_valM,
    output W_stat, W_icode, W_valE, W_valM, W_dstE, W_dstM
  );
endinterface

// File: rtl/data_mem.sv
// data_mem: byte-addressed little-endian data memory, 8-byte comb read, 8-byte clocked write.
// Ports: clk, addr_i (64b byte address), wdata_i, we_i, rdata_o. Contents are never reset.
module data_mem #(
  parameter int MEM_BYTES = 2048
) (
  input  logic        clk,
  input  logic [63:0] addr_i,
  input  logic [63:0] wdata_i,
  input  logic        we_i,
  output logic [63:0] rdata_o
);
  localparam int AW = $clog2(MEM_BYTES);
  logic [7:0] mem_q [MEM_BYTES];
  logic [63:0] byte_addr [8];
  always_comb begin
    rdata_o = '0;
    for (int i = 0; i < 8; i++) begin
      byte_addr[i] = addr_i + 64'(i);
      rdata_o[8*i +: 8] = (byte_addr[i] < 64'(MEM_BYTES)) ? mem_q[AW'(byte_addr[i])] : 8'h00;
    end
  end
  // Writers only assert we_i for in-range addresses, so truncation never wraps.
  always_ff @(posedge clk)
    if (we_i)
      for (int i = 0; i < 8; i++)
        mem_q[AW'(addr_i) + AW'(i)] <= wdata_i[8*i +: 8];
endmodule

// File: rtl/memory_stage.sv
// memory_stage: Y86-64 memory stage with M and W pipeline registers and data memory.
// Ports: clk, rst (sync active-high), bus (memory_stage_if.slave: e_* in, M_*/m_*/W_* out).
// Optional MEM_ALIGN_CHECK_EN: unaligned accesses raise an address error.
module memory_stage
  import y86_pkg::*;
#(
  parameter int MEM_BYTES = 2048
) (
  input logic             clk,
  input logic             rst,
  memory_stage_if.slave   bus
);
  m_reg_t m_q, m_d;
  w_reg_t w_q, w_d;
  logic rd, wr, align_err, dmem_error, we;
  logic [63:0] addr, rdata, m_val_m;
  logic [2:0] m_stat;
  assign addr = (m_q.icode == POPQ || m_q.icode == RET) ? m_q.val_a : m_q.val_e;
`ifdef MEM_ALIGN_CHECK_EN
  assign align_err = addr[2:0] != 3'd0;
`else
  assign align_err = 1'b0;
`endif
  always_comb begin
    m_d = bus.M_bubble ? M_BUBBLE
        : {bus.e_stat, bus.e_icode, bus.e_Cnd, bus.e_valE, bus.e_valA, bus.e_dstE, bus.e_dstM};
    rd = is_read(m_q.icode);
    wr = is_write(m_q.icode);
    // Unsigned 64-bit compare: huge addresses cannot wrap into range.
    dmem_error = (rd || wr) && (addr > 64'(MEM_BYTES - 8) || align_err);
    m_stat = dmem_error ? ADR : m_q.stat;
    m_val_m = (rd && !dmem_error) ? rdata : '0;
    // Only a clean store with no older exception in W may touch memory.
    we = wr && m_q.stat == AOK && !dmem_error && (w_q.stat == AOK || w_q.stat == BUB) && !rst;
    w_d = {m_stat, m_q.icode, m_q.val_e, m_val_m, m_q.dst_e, m_q.dst_m};
  end
  always_ff @(posedge clk) begin
    m_q <= rst ? M_BUBBLE : m_d;
    w_q <= rst ? W_BUBBLE : bus.W_stall ? w_q : w_d;
  end
  data_mem #(.MEM_BYTES(MEM_BYTES)) u_dmem (
    .clk     (clk),
    .addr_i  (addr),
    .wdata_i (m_q.val_a),
    .we_i    (we),
    .rdata_o (rdata)
  );
  assign bus.M_stat  = m_q.stat;
  assign bus.M_icode = m_q.icode;
  assign bus.M_Cnd   = m_q.cnd;
  assign bus.M_valE  = m_q.val_e;
  assign bus.M_valA  = m_q.val_a;
  assign bus.M_dstE  = m_q.dst_e;
  assign bus.M_dstM  = m_q.dst_m;
  assign bus.m_stat  = m_stat;
  assign bus.m_valM  = m_val_m;
  assign bus.W_stat  = w_q.stat;
  assign bus.W_icode = w_q.icode;
  assign bus.W_valE  = w_q.val_e;
  assign bus.W_valM  = w_q.val_m;
  assign bus.W_dstE  = w_q.dst_e;
  assign bus.W_dstM  = w_q.dst_m;
endmodule

// File: tb/tb_memory_stage.sv
// tb_memory_stage: directed self-checking bench for memory_stage (MEM_BYTES = 2048).
module tb_memory_stage;
  import y86_pkg::*;
  logic clk = 1'b0;
  logic rst;
  int n_vec = 0;
  int n_err = 0;
  memory_stage_if bus ();
  memory_stage #(.MEM_BYTES(2048)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic drive(input logic [2:0] st, input logic [3:0] ic, input logic [63:0] ve, input logic [63:0] va);
    bus.e_stat = st;
    bus.e_icode = ic;
    bus.e_Cnd = 1'b1;
    bus.e_valE = ve;
    bus.e_valA = va;
    bus.e_dstE = 4'h3;
    bus.e_dstM = 4'h4;
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  initial begin
    rst = 1'b1;
    bus.M_bubble = 1'b0;
    bus.W_stall = 1'b0;
    drive(AOK, NOP, 64'd0, 64'd0);
    tick();
    tick();
    chk("rst_m_stat", 64'(bus.m_stat), 64'd0);
    chk("rst_M_icode", 64'(bus.M_icode), 64'h1);
    chk("rst_M_dstM", 64'(bus.M_dstM), 64'hF);
    chk("rst_M_valE", bus.M_valE, 64'd0);
    chk("rst_m_valM", bus.m_valM, 64'd0);
    chk("rst_W_stat", 64'(bus.W_stat), 64'd0);
    chk("rst_W_icode", 64'(bus.W_icode), 64'h1);
    chk("rst_W_dstE", 64'(bus.W_dstE), 64'hF);
    chk("rst_W_valM", bus.W_valM, 64'd0);
    rst = 1'b0;
    drive(AOK, RMMOVQ, 64'h10, 64'h1122334455667788);
    tick();
    chk("st_M_icode", 64'(bus.M_icode), 64'h4);
    chk("st_m_stat", 64'(bus.m_stat), 64'h1);
    chk("st_m_valM", bus.m_valM, 64'd0);
    drive(AOK, MRMOVQ, 64'h10, 64'd0);
    tick();
    chk("ld_m_valM", bus.m_valM, 64'h1122334455667788);
    chk("ld_m_stat", 64'(bus.m_stat), 64'h1);
    chk("ld_W_icode_store", 64'(bus.W_icode), 64'h4);
    drive(AOK, RMMOVQ, 64'h40, 64'h99);
    tick();
    chk("ld_W_valM", bus.W_valM, 64'h1122334455667788);
    drive(AOK, PUSHQ, 64'h18, 64'hAB);
    tick();
    drive(AOK, POPQ, 64'h20, 64'h18);
    tick();
    chk("pop_m_valM", bus.m_valM, 64'hAB);
    drive(AOK, RET, 64'h0, 64'h18);
    tick();
    chk("ret_m_valM", bus.m_valM, 64'hAB);
    drive(AOK, RMMOVQ, 64'h7F8, 64'h5555);
    tick();
    drive(AOK, MRMOVQ, 64'd2041, 64'd0);
    tick();
    chk("oor_ld_m_stat", 64'(bus.m_stat), 64'h3);
    chk("oor_ld_m_valM", bus.m_valM, 64'd0);
    drive(AOK, MRMOVQ, 64'h7F8, 64'd0);
    tick();
    chk("edge_ld_m_stat", 64'(bus.m_stat), 64'h1);
    chk("edge_ld_m_valM", bus.m_valM, 64'h5555);
    chk("oor_W_stat", 64'(bus.W_stat), 64'h3);
    drive(AOK, NOP, 64'd0, 64'd0);
    tick();
    drive(AOK, RMMOVQ, 64'hFFFFFFFFFFFFFFF8, 64'hDEAD);
    tick();
    chk("oor_st_m_stat", 64'(bus.m_stat), 64'h3);
    drive(AOK, MRMOVQ, 64'h7F8, 64'd0);
    tick();
    chk("oor_st_no_write", bus.m_valM, 64'h5555);
    drive(AOK, NOP, 64'd0, 64'd0);
    tick();
    tick();
    bus.M_bubble = 1'b1;
    drive(AOK, IRMOVQ, 64'h5, 64'd0);
    tick();
    bus.M_bubble = 1'b0;
    chk("bub_M_icode", 64'(bus.M_icode), 64'h1);
    chk("bub_m_stat", 64'(bus.m_stat), 64'h0);
    chk("bub_M_dstE", 64'(bus.M_dstE), 64'hF);
    drive(HLT, HALT, 64'd0, 64'd0);
    tick();
    drive(AOK, NOP, 64'd0, 64'd0);
    tick();
    chk("hlt_W_stat", 64'(bus.W_stat), 64'h2);
    bus.W_stall = 1'b1;
    drive(AOK, RMMOVQ, 64'h40, 64'h77);
    tick();
    chk("stall_W_stat", 64'(bus.W_stat), 64'h2);
    chk("stall_W_icode", 64'(bus.W_icode), 64'h0);
    chk("stall_M_icode", 64'(bus.M_icode), 64'h4);
    drive(AOK, NOP, 64'd0, 64'd0);
    tick();
    chk("stall_W_hold", 64'(bus.W_stat), 64'h2);
    bus.W_stall = 1'b0;
    drive(AOK, MRMOVQ, 64'h40, 64'd0);
    tick();
    chk("stall_no_write", bus.m_valM, 64'h99);
    chk("unstall_W_stat", 64'(bus.W_stat), 64'h1);
    drive(AOK, RMMOVQ, 64'h13, 64'hCAFEBABE01020304);
    tick();
`ifdef MEM_ALIGN_CHECK_EN
    chk("align_st_m_stat", 64'(bus.m_stat), 64'h3);
`else
    chk("align_st_m_stat", 64'(bus.m_stat), 64'h1);
`endif
    drive(AOK, MRMOVQ, 64'h13, 64'd0);
    tick();
`ifdef MEM_ALIGN_CHECK_EN
    chk("align_ld_m_stat", 64'(bus.m_stat), 64'h3);
    chk("align_ld_m_valM", bus.m_valM, 64'd0);
`else
    chk("align_ld_m_stat", 64'(bus.m_stat), 64'h1);
    chk("align_ld_m_valM", bus.m_valM, 64'hCAFEBABE01020304);
`endif
    drive(AOK, NOP, 64'd0, 64'd0);
    tick();
    tick();
    drive(AOK, RMMOVQ, 64'h40, 64'h1234);
    tick();
    rst = 1'b1;
    drive(AOK, NOP, 64'd0, 64'd0);
    tick();
    rst = 1'b0;
    chk("rst_mid_M_icode", 64'(bus.M_icode), 64'h1);
    chk("rst_mid_W_dstE", 64'(bus.W_dstE), 64'hF);
    drive(AOK, MRMOVQ, 64'h40, 64'd0);
    tick();
    chk("rst_mid_no_write", bus.m_valM, 64'h99);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/memory_stage.md
# memory_stage

Memory stage of the Y86-64 five-stage pipeline, directly downstream of `execute`. It holds the M pipeline register, which captures `execute`'s `e_*` outputs. It owns the byte-addressed little-endian data memory and performs loads and stores. It holds the W pipeline register, which feeds write-back. `m_stat` and `W_stat` are returned to `execute` to gate condition-code updates.

## Interface
- `MEM_BYTES`, default 2048: data memory size in bytes; must be a multiple of 8.
- `clk` in 1: clock; all state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `e_stat` in 3: status from execute.
- `e_icode` in 4: instruction code.
- `e_Cnd` in 1: condition result from execute.
- `e_valE` in 64: ALU result.
- `e_valA` in 64: store data / pop address.
- `e_dstE`, `e_dstM` in 4 each: destination registers.
- `M_bubble` in 1: load a bubble into the M register this edge.
- `W_stall` in 1: hold the W register this edge.
- `M_stat`, `M_icode`, `M_Cnd`, `M_valE`, `M_valA`, `M_dstE`, `M_dstM` out: M register contents, same widths as the `e_*` inputs. Used for forwarding.
- `m_stat` out 3: post-memory status.
- `m_valM` out 64: load data.
- `W_stat` out 3, `W_icode` out 4, `W_valE` out 64, `W_valM` out 64, `W_dstE` out 4, `W_dstM` out 4: W register contents.

## Operation
- **M register:**
  - `rst` loads a bubble: stat BUB, icode NOP, Cnd 0, vals 0, dst RNONE.
  - Otherwise `M_bubble` loads a bubble.
  - Otherwise the M register loads the `e_*` inputs.
  - `rst` has priority over `M_bubble`.
- **Address select:** `M_valE` for RMMOVQ, MRMOVQ, PUSHQ, CALL; `M_valA` for POPQ, RET.
- **Read** for MRMOVQ, POPQ, RET. **Write** for RMMOVQ, PUSHQ, CALL; write data is `M_valA`, 8 bytes, little-endian.
- **Address error:**
  - `dmem_error` is set when a read or write is requested and the address is greater than MEM_BYTES−8, compared unsigned on the full 64 bits so there is no wrap.
  - `m_stat` = SADR if `dmem_error`, else `M_stat`.
- **m_valM:** combinational read of 8 bytes at the selected address. It is 0 when there is no read or when `dmem_error` is set.
- **Write enable** requires all of the following:
  - icode is a write;
  - `M_stat` is AOK;
  - no `dmem_error`;
  - `W_stat` is AOK or BUB.
  - A faulting or post-exception store never modifies memory.
- **W register:**
  - `rst` loads a bubble.
  - Otherwise `W_stall` holds all W fields.
  - Otherwise the W register loads `m_stat`, `M_icode`, `M_valE`, `m_valM`, `M_dstE`, `M_dstM`.
- **Reset:** memory contents are not reset.

## Timing
- The M register updates at edge N. `m_stat` and `m_valM` are valid combinationally in the same cycle. The memory write and the W capture occur at edge N+1.
- A load immediately following a store to the same address, one cycle later, returns the newly written data. No internal forwarding is needed.
- All outputs after reset: stat outputs BUB (3'd0), icode outputs NOP, dst outputs 4'hF, everything else 0.
- Reset mid-store: if `rst` is high at the write edge, the write is suppressed.
- `W_stall` does not affect M or memory writes.

## Configuration
- `MEM_ALIGN_CHECK_EN` defined: any read or write with address[2:0] ≠ 0 also sets `dmem_error`, which gives SADR and no write.
- `MEM_ALIGN_CHECK_EN` undefined: unaligned accesses are legal byte-wise accesses.

## Structure
- Shared package `y86_pkg` holds:
  - stat codes: BUB=0, AOK=1, HLT=2, ADR=3, INS=4;
  - icode constants HALT..POPQ (0x0–0xB);
  - `RNONE` = 4'hF.
- Sub-module `data_mem`:
  - byte array;
  - combinational 8-byte read port;
  - clocked 8-byte write port with write enable;
  - `MEM_BYTES` parameter.

## Test plan
- **Reset:** hold `rst` for 2 cycles. Every output is at its reset value: `m_stat`=0, `W_dstE`=F.
- **Store then load:**
  - Store: RMMOVQ with `valE`=0x10, `valA`=0x1122334455667788.
  - Load: next cycle, MRMOVQ with `valE`=0x10.
  - Response: `m_valM`=0x1122334455667788. `W_valM` carries the same value one edge later.
- **POPQ:** with `valA`=0x18 after PUSHQ with `valE`=0x18, data 0xAB, `m_valM`=0xAB. RET also reads from `valA`.
- **Out of range:**
  - MRMOVQ with `valE`=MEM_BYTES−7 gives `m_stat`=ADR and `m_valM`=0.
  - RMMOVQ with `valE`=0xFFFFFFFFFFFFFFF8 gives ADR and leaves memory unchanged.
- **Bubble and stall:**
  - `M_bubble` gives M_icode=NOP and `m_stat`=BUB next cycle.
  - `W_stall` with W_stat=HLT holds W. A store in M during that stall is not written.
- **Alignment:** `valE`=0x13.
  - Macro defined: ADR.
  - Macro undefined: the store and load succeed and return the stored value.
